// File: rtl/npc_seq_pkg.sv
// Shared next-PC constants and npc-source encoding, also consumed by the exception unit and CP0.
// Constants only: no latency, no backpressure.
package npc_seq_pkg;

  localparam logic [31:0] DEF_RESET_PC    = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_HANDLER = 32'h0000_4180;
  localparam int          DEF_STEP        = 4;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_J    = 3'd2,
    SRC_JR   = 3'd3,
    SRC_PEND = 3'd4,
    SRC_ERET = 3'd5,
    SRC_EXC  = 3'd6
  } npc_src_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pend_state_e;

  // Exception and ERET load pc even while fetch is stalled.
  function automatic logic src_forces_load(input npc_src_e src);
    return (src == SRC_EXC) || (src == SRC_ERET);
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Combinational next-PC priority mux: exception > ERET > branch > jump > jump-register > pending > sequential.
// Latency: zero (pure combinational); backpressure: none, stall is deliberately not an input.
module npc_sel
  import npc_seq_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] EXC_HANDLER = WIDTH'(DEF_EXC_HANDLER),
  parameter int               STEP        = DEF_STEP
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             exc_occur,
  input  logic             eret,
  input  logic             branch,
  input  logic             jump,
  input  logic             jump_r,
  input  logic [WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0] j_addr,
  input  logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] epc,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_addr,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] npc,
  output npc_src_e         src,
  output logic             redir,
  output logic [WIDTH-1:0] redir_addr
);

  always_comb begin
    redir      = branch | jump | jump_r;
    redir_addr = rd;
    if (branch) begin
      redir_addr = b_addr;
    end else if (jump) begin
      redir_addr = j_addr;
    end

    pc4 = pc + WIDTH'(STEP);
    npc = pc4;
    src = SRC_SEQ;
    if (exc_occur) begin
      npc = EXC_HANDLER;
      src = SRC_EXC;
    end else if (eret) begin
      npc = epc;
      src = SRC_ERET;
    end else if (redir) begin
      npc = redir_addr;
      src = branch ? SRC_BR : (jump ? SRC_J : SRC_JR);
    end else if (pend_valid) begin
      npc = pend_addr;
      src = SRC_PEND;
    end
  end

endmodule

// File: rtl/npc_seq.sv
// Fetch PC register with stall, one-entry pending-redirect buffer and delay-slot flag; NPC_ALIGN_CHECK_EN adds adel.
// Latency: redirect lands on pc one edge after acceptance or after stall falls; stall holds pc but never blocks exc/eret.
module npc_seq
  import npc_seq_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_HANDLER = WIDTH'(DEF_EXC_HANDLER),
  parameter int               STEP        = DEF_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc_occur,
  input  logic             eret,
  input  logic             branch,
  input  logic             jump,
  input  logic             jump_r,
  input  logic [WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0] j_addr,
  input  logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] npc,
  output logic             exc_bd,
`ifdef NPC_ALIGN_CHECK_EN
  output logic             adel,
`endif
  output logic             redir_pend
);

  pend_state_e      state;
  logic [WIDTH-1:0] pend_addr;
  logic             pend_valid;
  logic             bd_q;
  logic             redir;
  logic [WIDTH-1:0] redir_addr;
  npc_src_e         src;

  assign pend_valid = (state == ST_PEND);

  npc_sel #(
    .WIDTH      (WIDTH),
    .EXC_HANDLER(EXC_HANDLER),
    .STEP       (STEP)
  ) u_sel (
    .pc        (pc),
    .exc_occur (exc_occur),
    .eret      (eret),
    .branch    (branch),
    .jump      (jump),
    .jump_r    (jump_r),
    .b_addr    (b_addr),
    .j_addr    (j_addr),
    .rd        (rd),
    .epc       (epc),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .pc4       (pc4),
    .npc       (npc),
    .src       (src),
    .redir     (redir),
    .redir_addr(redir_addr)
  );

`ifdef NPC_ALIGN_CHECK_EN
  logic adel_q;
  assign adel = adel_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      state     <= ST_RUN;
      pend_addr <= '0;
      bd_q      <= 1'b0;
`ifdef NPC_ALIGN_CHECK_EN
      adel_q    <= 1'b0;
`endif
    end else if (src_forces_load(src) || !stall) begin
      // Any load consumes the buffer: a same-cycle redirect has already won the mux.
      pc    <= npc;
      state <= ST_RUN;
      bd_q  <= 1'b0;
`ifdef NPC_ALIGN_CHECK_EN
      adel_q <= (src != SRC_EXC) && (src != SRC_SEQ) && (|npc[1:0]);
`endif
    end else begin
      if (redir) begin
        pend_addr <= redir_addr;
        state     <= ST_PEND;
      end
      // Keep the flag on the delay-slot instruction held in F for the whole stall.
      bd_q <= redir | pend_valid;
    end
  end

  assign exc_bd     = redir | pend_valid | bd_q;
  assign redir_pend = pend_valid;

endmodule

// File: tb/tb_npc_seq.sv
// Scoreboard bench for npc_seq: each row drives inputs, queues the expected outputs, and compares them at the falling edge.
`timescale 1ns/1ps
module tb_npc_seq;

  localparam logic [6:0] C_RST  = 7'b1000000;
  localparam logic [6:0] C_STL  = 7'b0100000;
  localparam logic [6:0] C_EXC  = 7'b0010000;
  localparam logic [6:0] C_ERET = 7'b0001000;
  localparam logic [6:0] C_BR   = 7'b0000100;
  localparam logic [6:0] C_J    = 7'b0000010;
  localparam logic [6:0] C_JR   = 7'b0000001;
  localparam logic [6:0] C_NONE = 7'b0000000;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [31:0] b, jt, r, e;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc, pc4, npc;
    logic        pend, bd, adel;
  } exp_t;

  logic        clk, reset, stall, exc_occur, eret, branch, jump, jump_r;
  logic [31:0] b_addr, j_addr, rd, epc;
  logic [31:0] pc, pc4, npc;
  logic        exc_bd, redir_pend, adel_obs;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad   = 0;

  npc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .exc_occur (exc_occur),
    .eret      (eret),
    .branch    (branch),
    .jump      (jump),
    .jump_r    (jump_r),
    .b_addr    (b_addr),
    .j_addr    (j_addr),
    .rd        (rd),
    .epc       (epc),
    .pc        (pc),
    .pc4       (pc4),
    .npc       (npc),
    .exc_bd    (exc_bd),
`ifdef NPC_ALIGN_CHECK_EN
    .adel      (adel_obs),
`endif
    .redir_pend(redir_pend)
  );

`ifndef NPC_ALIGN_CHECK_EN
  assign adel_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [6:0] ctl, input logic [31:0] b, jt, r, e,
                     input logic [31:0] xpc, xnpc, input logic xpend, xbd, xadel);
    stim_t s;
    exp_t  x;
    s = '{ctl: ctl, b: b, jt: jt, r: r, e: e};
    x = '{pc: xpc, pc4: xpc + 32'd4, npc: xnpc, pend: xpend, bd: xbd, adel: xadel};
    stim_q.push_back(s);
    exp_q.push_back(x);
  endtask

  task automatic apply(input stim_t s);
    {reset, stall, exc_occur, eret, branch, jump, jump_r} = s.ctl;
    b_addr = s.b;
    j_addr = s.jt;
    rd     = s.r;
    epc    = s.e;
  endtask

  task automatic test_reset();
    exp_t x, o;
    int   row = 0;
    add(C_RST,  0, 0, 0, 0, 32'h3000, 32'h3004, 0, 0, 0);
    add(C_NONE, 0, 0, 0, 0, 32'h3000, 32'h3004, 0, 0, 0);
    add(C_NONE, 0, 0, 0, 0, 32'h3004, 32'h3008, 0, 0, 0);
    add(C_NONE, 0, 0, 0, 0, 32'h3008, 32'h300C, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL reset row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    exp_t x, o;
    int   row = 0;
    add(C_NONE,      0,        0,        0,        0, 32'h300C, 32'h3010, 0, 0, 0);
    add(C_BR | C_J,  32'h3100, 32'h3150, 0,        0, 32'h3010, 32'h3100, 0, 1, 0);
    add(C_J | C_JR,  0,        32'h3120, 32'h3130, 0, 32'h3100, 32'h3120, 0, 1, 0);
    add(C_NONE,      0,        0,        0,        0, 32'h3120, 32'h3124, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL branch row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_pend();
    exp_t x, o;
    int   row = 0;
    add(C_STL | C_J, 0, 32'h3200, 0, 0, 32'h3124, 32'h3200, 0, 1, 0);
    add(C_STL,       0, 0,        0, 0, 32'h3124, 32'h3200, 1, 1, 0);
    add(C_STL,       0, 0,        0, 0, 32'h3124, 32'h3200, 1, 1, 0);
    add(C_NONE,      0, 0,        0, 0, 32'h3124, 32'h3200, 1, 1, 0);
    add(C_NONE,      0, 0,        0, 0, 32'h3200, 32'h3204, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL stall_pend row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overwrite();
    exp_t x, o;
    int   row = 0;
    add(C_STL | C_J,  0, 32'h3200, 0,        0, 32'h3204, 32'h3200, 0, 1, 0);
    add(C_STL | C_JR, 0, 0,        32'h3300, 0, 32'h3204, 32'h3300, 1, 1, 0);
    add(C_STL,        0, 0,        0,        0, 32'h3204, 32'h3300, 1, 1, 0);
    add(C_NONE,       0, 0,        0,        0, 32'h3204, 32'h3300, 1, 1, 0);
    add(C_NONE,       0, 0,        0,        0, 32'h3300, 32'h3304, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL overwrite row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exc_priority();
    exp_t x, o;
    int   row = 0;
    add(C_STL | C_J,                     0,        32'h3400, 0, 0,        32'h3304, 32'h3400, 0, 1, 0);
    add(C_STL | C_EXC | C_ERET | C_BR,   32'h3600, 0,        0, 32'h3500, 32'h3304, 32'h4180, 1, 1, 0);
    add(C_STL,                           0,        0,        0, 0,        32'h4180, 32'h4184, 0, 0, 0);
    add(C_NONE,                          0,        0,        0, 0,        32'h4180, 32'h4184, 0, 0, 0);
    add(C_STL | C_ERET,                  0,        0,        0, 32'h3800, 32'h4184, 32'h3800, 0, 0, 0);
    add(C_NONE,                          0,        0,        0, 0,        32'h3800, 32'h3804, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL exc_priority row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_pend();
    exp_t x, o;
    int   row = 0;
    add(C_STL | C_BR,  32'h3900, 0, 0, 0, 32'h3804, 32'h3900, 0, 1, 0);
    add(C_STL | C_RST, 0,        0, 0, 0, 32'h3804, 32'h3900, 1, 1, 0);
    add(C_NONE,        0,        0, 0, 0, 32'h3000, 32'h3004, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL reset_in_pend row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    exp_t x, o;
    int   row = 0;
    add(C_J,    0, 32'hFFFF_FFFC, 0, 0, 32'h3004,      32'hFFFF_FFFC, 0, 1, 0);
    add(C_NONE, 0, 0,             0, 0, 32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0);
    add(C_NONE, 0, 0,             0, 0, 32'h0000_0000, 32'h0000_0004, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL wrap row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask

`ifdef NPC_ALIGN_CHECK_EN
  task automatic test_align();
    exp_t x, o;
    int   row = 0;
    add(C_ERET, 0, 0, 0, 32'h3002, 32'h0000_0004, 32'h3002, 0, 0, 0);
    add(C_NONE, 0, 0, 0, 0,        32'h3002,      32'h3006, 0, 0, 1);
    add(C_NONE, 0, 0, 0, 0,        32'h3006,      32'h300A, 0, 0, 0);
    while (stim_q.size() != 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      x = exp_q.pop_front();
      o = '{pc: pc, pc4: pc4, npc: npc, pend: redir_pend, bd: exc_bd, adel: adel_obs};
      total++;
      if (o !== x) begin
        bad++;
        $display("FAIL align row%0d: got pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b want pc=%h pc4=%h npc=%h pend=%b bd=%b adel=%b",
                 row, o.pc, o.pc4, o.npc, o.pend, o.bd, o.adel, x.pc, x.pc4, x.npc, x.pend, x.bd, x.adel);
      end
      row++;
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    {stall, exc_occur, eret, branch, jump, jump_r} = '0;
    b_addr = '0;
    j_addr = '0;
    rd     = '0;
    epc    = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_branch();
    test_stall_pend();
    test_overwrite();
    test_exc_priority();
    test_reset_in_pend();
    test_wrap();
`ifdef NPC_ALIGN_CHECK_EN
    test_align();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
